// File: rtl/equiv_sequencer.sv
// Equivalence sequencer: replays stored stimulus vectors into a reference and a
// synthesized DUT, counts unequal outputs and compacts y_a into a 32-bit MISR.
module equiv_sequencer #(
   parameter int IN_W  = 63,
   parameter int OUT_W = 421,
   parameter int DEPTH = 32,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             vec_wr_en,
   input  logic [AW-1:0]    vec_wr_addr,
   input  logic [IN_W-1:0]  vec_wr_data,
   input  logic [AW:0]      num_vec,
   input  logic [3:0]       hold,
   output logic [IN_W-1:0]  stim,
   input  logic [OUT_W-1:0] y_a,
   input  logic [OUT_W-1:0] y_b,
   output logic             busy,
   output logic             done,
   output logic             mismatch,
   output logic [AW:0]      mismatch_cnt,
   output logic [AW-1:0]    first_fail_idx,
   output logic [31:0]      signature
);

   localparam int          NCH      = (OUT_W + 31) / 32;
   localparam logic [AW:0] DEPTH_V  = (AW+1)'(DEPTH);
   localparam logic [31:0] SIG_SEED = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_WAIT  = 3'd2,
      S_CHECK = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   // Zero-pad to whole 32-bit chunks and XOR them together.
   function automatic logic [31:0] fold32(input logic [OUT_W-1:0] v);
      logic [NCH*32-1:0] pad;
      logic [31:0]       acc;
      pad = '0;
      pad[OUT_W-1:0] = v;
      acc = 32'h0000_0000;
      for (int i = 0; i < NCH; i++) begin
         acc = acc ^ pad[i*32 +: 32];
      end
      return acc;
   endfunction

   function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [31:0] f);
      return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]} ^ f;
   endfunction

   logic [IN_W-1:0] mem_r [DEPTH];
   state_t          state_r;
   state_t          state_next_s;
   logic [IN_W-1:0] stim_r;
   logic            busy_r;
   logic            done_r;
   logic            mismatch_r;
   logic [AW:0]     mismatch_cnt_r;
   logic [AW-1:0]   first_fail_idx_r;
   logic [31:0]     sig_r;
   logic [AW-1:0]   idx_r;
   logic [3:0]      cnt_r;
   logic [AW:0]     nv_r;
   logic [3:0]      hold_r;
   logic [AW:0]     nv_clamp_s;
   logic            last_s;
   logic            neq_s;
   logic [31:0]     sig_next_s;

   // Vector memory: loaded only while idle, never reset.
   always_ff @(posedge clk) begin
      if (vec_wr_en && (state_r == S_IDLE) && !rst) begin
         mem_r[vec_wr_addr] <= vec_wr_data;
      end
   end

   // Datapath helpers for the current vector.
   always_comb begin
      nv_clamp_s = (num_vec > DEPTH_V) ? DEPTH_V : num_vec;
      last_s     = ({1'b0, idx_r} == (nv_r - (AW+1)'(1)));
      neq_s      = (y_a != y_b);
      sig_next_s = misr_step(sig_r, fold32(y_a));
   end

   // Next-state decode.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               state_next_s = (num_vec == '0) ? S_DONE : S_LOAD;
            end else begin
               state_next_s = S_IDLE;
            end
         end
         S_LOAD: state_next_s = S_WAIT;
         S_WAIT: begin
            if (cnt_r == 4'd0) begin
               state_next_s = S_CHECK;
            end else begin
               state_next_s = S_WAIT;
            end
         end
         S_CHECK: begin
            if (last_s) begin
               state_next_s = S_DONE;
            end else begin
               state_next_s = S_LOAD;
            end
         end
         S_DONE:  state_next_s = S_IDLE;
         default: state_next_s = S_IDLE;
      endcase
   end

   // State register, run bookkeeping and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r          <= S_IDLE;
         stim_r           <= '0;
         busy_r           <= 1'b0;
         done_r           <= 1'b0;
         mismatch_r       <= 1'b0;
         mismatch_cnt_r   <= '0;
         first_fail_idx_r <= '0;
         sig_r            <= SIG_SEED;
         idx_r            <= '0;
         cnt_r            <= 4'd0;
         nv_r             <= '0;
         hold_r           <= 4'd0;
      end else begin
         state_r <= state_next_s;
         busy_r  <= (state_next_s != S_IDLE);
         done_r  <= (state_next_s == S_DONE);
         case (state_r)
            S_IDLE: begin
               if (start) begin
                  nv_r             <= nv_clamp_s;
                  hold_r           <= hold;
                  idx_r            <= '0;
                  mismatch_r       <= 1'b0;
                  mismatch_cnt_r   <= '0;
                  first_fail_idx_r <= '0;
                  sig_r            <= SIG_SEED;
               end
            end
            S_LOAD: begin
               stim_r <= mem_r[idx_r];
               cnt_r  <= hold_r;
            end
            S_WAIT: begin
               if (cnt_r != 4'd0) begin
                  cnt_r <= cnt_r - 4'd1;
               end
            end
            S_CHECK: begin
               if (neq_s) begin
                  mismatch_r     <= 1'b1;
                  mismatch_cnt_r <= mismatch_cnt_r + (AW+1)'(1);
                  if (!mismatch_r) begin
                     first_fail_idx_r <= idx_r;
                  end
               end
               sig_r <= sig_next_s;
               if (!last_s) begin
                  idx_r <= idx_r + AW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign stim           = stim_r;
   assign busy           = busy_r;
   assign done           = done_r;
   assign mismatch       = mismatch_r;
   assign mismatch_cnt   = mismatch_cnt_r;
   assign first_fail_idx = first_fail_idx_r;
   assign signature      = sig_r;

endmodule

// File: tb/tb_equiv_sequencer.sv
// Self-checking bench for equiv_sequencer: directed scenarios plus random runs
// checked every cycle against a run-level behavioural model.
module tb_equiv_sequencer;

   localparam int IN_W  = 63;
   localparam int OUT_W = 421;
   localparam int DEPTH = 32;
   localparam int AW    = 5;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic             vec_wr_en = 1'b0;
   logic [AW-1:0]    vec_wr_addr = '0;
   logic [IN_W-1:0]  vec_wr_data = '0;
   logic [AW:0]      num_vec = '0;
   logic [3:0]       hold = 4'd0;
   logic [IN_W-1:0]  stim;
   logic [OUT_W-1:0] y_a, y_b;
   logic             busy, done, mismatch;
   logic [AW:0]      mismatch_cnt;
   logic [AW-1:0]    first_fail_idx;
   logic [31:0]      signature;

   equiv_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .start(start), .vec_wr_en(vec_wr_en),
      .vec_wr_addr(vec_wr_addr), .vec_wr_data(vec_wr_data), .num_vec(num_vec),
      .hold(hold), .stim(stim), .y_a(y_a), .y_b(y_b), .busy(busy), .done(done),
      .mismatch(mismatch), .mismatch_cnt(mismatch_cnt),
      .first_fail_idx(first_fail_idx), .signature(signature)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Emulated DUT pair: y_a mode 0 = function of stim, 1 = zeros, 2 = ones.
   int             ya_mode = 0;
   int             fault_mode = 0;   // 0 none, 1 stim==fault_stim, 2 stim[3:0]==fault_key
   logic [IN_W-1:0] fault_stim = '0;
   logic [3:0]      fault_key = 4'd0;

   function automatic logic [OUT_W-1:0] ya_of(input logic [IN_W-1:0] s, input int m);
      logic [7*IN_W-1:0] rep;
      rep = {7{s}};
      if (m == 1) return '0;
      if (m == 2) return '1;
      return rep[OUT_W-1:0];
   endfunction

   function automatic logic [OUT_W-1:0] flip_of(input logic [IN_W-1:0] s, input int fm,
                                                input logic [IN_W-1:0] fs, input logic [3:0] fk);
      logic [OUT_W-1:0] f;
      f = '0;
      if (fm == 1 && s == fs) f[0] = 1'b1;
      if (fm == 2 && s[3:0] == fk) f[OUT_W-1] = 1'b1;
      return f;
   endfunction

   assign y_a = ya_of(stim, ya_mode);
   assign y_b = y_a ^ flip_of(stim, fault_mode, fault_stim, fault_key);

   // Behavioural model: bitwise fold by position modulo 32, then one MISR step.
   function automatic logic [31:0] model_fold(input logic [OUT_W-1:0] v);
      logic [31:0] acc;
      acc = 32'h0;
      for (int i = 0; i < OUT_W; i++) acc[i % 32] = acc[i % 32] ^ v[i];
      return acc;
   endfunction

   function automatic logic [31:0] model_misr(input logic [31:0] s, input logic [31:0] f);
      logic fb;
      fb = s[31] ^ s[21] ^ s[1] ^ s[0];
      return ((s << 1) | {31'h0, fb}) ^ f;
   endfunction

   logic [IN_W-1:0] shadow [DEPTH];

   // Expected behaviour: busy window [win_s, win_e], done at win_e, results from res_from.
   int          win_s = 1, win_e = 0, res_from = 1 << 30;
   bit          done_ok = 1'b0;
   bit          armed = 1'b0;
   logic        exp_mm = 1'b0;
   logic [AW:0] exp_cnt = '0;
   logic [AW-1:0] exp_ffi = '0;
   logic [31:0] exp_sig = 32'hFFFF_FFFF;
   logic [IN_W-1:0] exp_stim = '0;
   logic        exp_busy, exp_done;

   assign exp_busy = (cyc >= win_s) && (cyc <= win_e);
   assign exp_done = done_ok && (cyc == win_e);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      if (armed) begin
         chk("busy", busy, exp_busy);
         chk("done", done, exp_done);
         if (cyc >= res_from && !exp_busy) begin
            chk("mismatch", mismatch, exp_mm);
            chk("mismatch_cnt", mismatch_cnt, exp_cnt);
            chk("first_fail_idx", first_fail_idx, exp_ffi);
            chk("signature", signature, exp_sig);
            chk("stim", stim, exp_stim);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input logic [IN_W-1:0] d);
      vec_wr_en = 1'b1; vec_wr_addr = AW'(a); vec_wr_data = d;
      shadow[a] = d;
      step();
      vec_wr_en = 1'b0;
   endtask

   task automatic start_run(input int n, input int h);
      int nc, c, ffi;
      logic [31:0] sig;
      logic [IN_W-1:0] s;
      bit mm;
      nc = (n > DEPTH) ? DEPTH : n;
      c = 0; ffi = 0; mm = 1'b0; sig = 32'hFFFF_FFFF;
      for (int v = 0; v < nc; v++) begin
         s = shadow[v];
         if (flip_of(s, fault_mode, fault_stim, fault_key) != '0) begin
            if (!mm) ffi = v;
            mm = 1'b1;
            c++;
         end
         sig = model_misr(sig, model_fold(ya_of(s, ya_mode)));
      end
      exp_mm = mm; exp_cnt = (AW+1)'(c); exp_ffi = AW'(ffi); exp_sig = sig;
      if (nc > 0) exp_stim = shadow[nc-1];
      num_vec = (AW+1)'(n); hold = 4'(h); start = 1'b1;
      win_s = cyc + 1;
      win_e = win_s + nc * (h + 3);
      done_ok = 1'b1;
      res_from = win_e + 1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = -1;
      for (int i = 0; i < 2000; i++) begin
         if (done) begin
            lat = cyc - win_s;
            break;
         end
         step();
      end
      step();
   endtask

   int lat;
   logic [63:0] rnd;

   initial begin
      step();
      exp_stim = '0;
      res_from = cyc;
      armed = 1'b1;
      rst = 1'b0;
      step();

      for (int i = 0; i < DEPTH; i++) begin
         rnd = {$urandom, $urandom};
         wr(i, rnd[IN_W-1:0]);
      end
      wr(0, 63'h0);
      wr(1, 63'h1);
      wr(2, 63'h7FFF_FFFF_FFFF_FFFF);

      // Matching DUTs, three vectors, no settle.
      start_run(3, 0);
      wait_done(lat);
      chk("lat_3x0", 64'(lat), 64'd9);
      chk("clean_mm", mismatch, 64'd0);
      chk("clean_cnt", mismatch_cnt, 64'd0);

      // Single flipped bit on vector 1.
      fault_mode = 1; fault_stim = 63'h1;
      start_run(3, 0);
      wait_done(lat);
      chk("f1_mm", mismatch, 64'd1);
      chk("f1_cnt", mismatch_cnt, 64'd1);
      chk("f1_idx", first_fail_idx, 64'd1);
      fault_mode = 0;

      // Empty run.
      start_run(0, 0);
      wait_done(lat);
      chk("lat_empty", 64'(lat), 64'd0);
      chk("empty_sig", signature, 64'hFFFF_FFFF);
      chk("empty_cnt", mismatch_cnt, 64'd0);

      // All-ones y_a: pins the model fold and MISR.
      chk("model_fold", model_fold('1), 64'hFFFF_FFE0);
      chk("model_misr", model_misr(32'hFFFF_FFFF, 32'hFFFF_FFE0), 64'h0000_001E);
      ya_mode = 2;
      start_run(1, 2);
      wait_done(lat);
      chk("lat_1x2", 64'(lat), 64'd5);
      chk("ones_sig", signature, 64'h0000_001E);

      // Abort a long run with rst, then rerun it completely.
      ya_mode = 1;
      start_run(32, 15);
      repeat (100) step();
      rst = 1'b1;
      win_e = cyc; done_ok = 1'b0; res_from = cyc + 1;
      exp_mm = 1'b0; exp_cnt = '0; exp_ffi = '0; exp_sig = 32'hFFFF_FFFF; exp_stim = '0;
      step();
      rst = 1'b0;
      step();
      chk("abort_busy", busy, 64'd0);
      chk("abort_stim", stim, 64'd0);
      start_run(32, 15);
      wait_done(lat);
      chk("lat_32x15", 64'(lat), 64'd576);

      // start and write while busy are dropped.
      ya_mode = 0;
      start_run(4, 1);
      repeat (3) step();
      vec_wr_en = 1'b1; vec_wr_addr = '0; vec_wr_data = 63'h5A5A; start = 1'b1;
      step();
      vec_wr_en = 1'b0; start = 1'b0;
      wait_done(lat);
      chk("lat_busy_start", 64'(lat), 64'd16);
      start_run(1, 0);
      wait_done(lat);
      chk("slot0_kept", stim, 64'd0);

      // Write and start in the same idle cycle: new data is used.
      vec_wr_en = 1'b1; vec_wr_addr = 5'd1; vec_wr_data = 63'h1234_5678_9ABC;
      shadow[1] = 63'h1234_5678_9ABC;
      start_run(2, 0);
      vec_wr_en = 1'b0;
      wait_done(lat);
      chk("same_cycle_wr", stim, 64'h1234_5678_9ABC);

      // Randomized runs.
      for (int r = 0; r < 12; r++) begin
         int n, h, nw;
         nw = $urandom_range(0, 4);
         for (int w = 0; w < nw; w++) begin
            rnd = {$urandom, $urandom};
            wr($urandom_range(0, DEPTH-1), rnd[IN_W-1:0]);
         end
         fault_mode = ($urandom_range(0, 2) == 0) ? 0 : 2;
         fault_key = 4'($urandom_range(0, 15));
         n = $urandom_range(0, 40);
         h = $urandom_range(0, 3);
         start_run(n, h);
         wait_done(lat);
         chk("rand_lat", 64'(lat), 64'(((n > DEPTH) ? DEPTH : n) * (h + 3)));
      end

      step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/equiv_sequencer.md
EQUIV_SEQUENCER -- requirements
Module: equiv_sequencer

Interface
REQ-001 Parameter IN_W, default 63, width of the packed DUT stimulus {wire3,wire2,wire1,wire0}.
REQ-002 Parameter OUT_W, default 421, width of each DUT output y.
REQ-003 Parameter DEPTH, default 32, number of stimulus vector slots (power of two).
REQ-004 Port clk, input, 1, single clock; all logic is updated on the posedge.
REQ-005 Port rst, input, 1, synchronous, active-high reset.
REQ-006 Port start, input, 1, one-cycle pulse that begins a run.
REQ-007 Port vec_wr_en, input, 1, writes vec_wr_data into slot vec_wr_addr.
REQ-008 Port vec_wr_addr, input, log2(DEPTH), vector slot index.
REQ-009 Port vec_wr_data, input, IN_W, stimulus vector.
REQ-010 Port num_vec, input, log2(DEPTH)+1, number of vectors per run; sampled on start.
REQ-011 Port hold, input, 4, number of extra settle cycles per vector; sampled on start.
REQ-012 Port stim, output, IN_W, registered stimulus driven to both DUT instances.
REQ-013 Ports y_a and y_b, input, OUT_W each, outputs of the reference DUT and the synthesized DUT.
REQ-014 Port busy, output, 1, high while the state is not IDLE.
REQ-015 Port done, output, 1, one-cycle pulse at the end of a run.
REQ-016 Port mismatch, output, 1, sticky flag: at least one vector compared unequal in the last run.
REQ-017 Port mismatch_cnt, output, log2(DEPTH)+1, count of unequal vectors in the last run.
REQ-018 Port first_fail_idx, output, log2(DEPTH), index of the first unequal vector; valid only when mismatch=1.
REQ-019 Port signature, output, 32, MISR over y_a for every checked vector.

Function
REQ-020 The FSM SHALL have states IDLE, LOAD, WAIT, CHECK and DONE.
REQ-021 IDLE + start: latch num_vec (clamped to DEPTH) and hold; clear idx, mismatch, mismatch_cnt and first_fail_idx; seed signature to 32'hFFFFFFFF; go to LOAD, or to DONE if num_vec=0.
REQ-022 LOAD: stim <= mem[idx]; cnt <= hold; go to WAIT.
REQ-023 WAIT: while cnt!=0, decrement cnt; when cnt=0, go to CHECK, so WAIT lasts hold+1 cycles.
REQ-024 CHECK: compare y_a and y_b on all OUT_W bits.
REQ-025 CHECK on inequality: set mismatch and increment mismatch_cnt; if this is the first mismatch, record first_fail_idx=idx.
REQ-026 CHECK: update signature; then, if idx=num_vec-1, go to DONE, else increment idx and go to LOAD.
REQ-027 Per-vector cost SHALL be exactly hold+3 cycles, and DONE SHALL be entered N*(hold+3) posedges after the edge that sampled start.
REQ-028 DONE: done=1 for exactly one cycle, then go to IDLE.
REQ-029 Results and stim SHALL hold their values until the next start or rst.
REQ-030 Signature fold: zero-pad y_a to a multiple of 32 bits, then XOR all 32-bit chunks to form F.
REQ-031 Signature update: sig <= {sig[30:0], sig[31]^sig[21]^sig[1]^sig[0]} ^ F.
REQ-032 vec_wr_en SHALL be honoured only in IDLE; writes while busy are dropped, and the memory is never reset.
REQ-033 start while busy SHALL be ignored; start and vec_wr_en in the same IDLE cycle perform both, and the run uses the old slot contents for that slot only if it is read in the same cycle (it is not; LOAD is at least one cycle later, so the new data is used).
REQ-034 mismatch_cnt SHALL never wrap, since its maximum is DEPTH.

Reset
REQ-035 rst SHALL force state=IDLE, stim=0, busy=0, done=0, mismatch=0, mismatch_cnt=0, first_fail_idx=0 and signature=32'hFFFFFFFF on the next posedge.
REQ-036 rst SHALL take priority over start and over any in-progress run; a run aborted by rst produces no done pulse.

Verification
REQ-037 Write slots 0..2 with 0, 63'h1, 63'h7FFF_FFFF_FFFF_FFFF; set num_vec=3, hold=0, y_b=y_a; pulse start -> done pulses 9 cycles after the start edge, mismatch=0, mismatch_cnt=0.
REQ-038 Same setup, but force y_b[0] inverted only while stim=63'h1 -> mismatch=1, mismatch_cnt=1, first_fail_idx=1.
REQ-039 Set num_vec=0 and pulse start -> DONE is entered on the next edge, done pulses, mismatch_cnt=0, signature=32'hFFFFFFFF.
REQ-040 Set num_vec=32, hold=15, y_a=y_b=0; pulse start, then assert rst after 100 cycles -> outputs return to reset values, no done pulse, and a fresh start completes in 32*18=576 cycles.
REQ-041 Pulse start and vec_wr_en while busy -> neither has any effect: the run length is unchanged and the slot contents are unchanged after DONE.
REQ-042 Tie y_a to all-ones, num_vec=1, hold=2 -> the signature equals the software MISR model (F=32'hFFFFFFFF ^ 32'h0000001F for OUT_W=421) applied once to seed 32'hFFFFFFFF.
